// File: rtl/ama_riscv_csr_cnt.sv
// Machine counter bank: mcycle, minstret, NUM_HPM event counters and mcountinhibit,
// accessed as 32-bit halves with assign/set/clear semantics and a 1-cycle registered read.
module ama_riscv_csr_cnt #(
   parameter int NUM_HPM = 4,
   parameter int CNT_W   = 64
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     csr_en,
   input  logic                                     csr_we,
   input  logic [1:0]                               csr_op_sel,
   input  logic [11:0]                              csr_addr,
   input  logic [31:0]                              csr_wdata,
   input  logic                                     inst_retired,
   input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_evt,
   output logic [31:0]                              csr_rdata,
   output logic                                     csr_rvalid,
   output logic                                     csr_hit
);

   typedef enum logic [1:0] {
      OP_NONE   = 2'd0,
      OP_ASSIGN = 2'd1,
      OP_SET    = 2'd2,
      OP_CLR    = 2'd3
   } csr_op_sel_t;

   localparam int               NCNT     = 3 + NUM_HPM;
   localparam logic [31:0]      INH_MASK = 32'(((64'd1 << NCNT) - 64'd1) & ~64'd2);
   localparam logic [11:0]      ADDR_INH = 12'h320;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // Slot 1 (0xB01/0xB81) is reserved and stays zero so that slot index == addr[4:0]
   logic [CNT_W-1:0] cnt_reg  [NCNT];
   logic [CNT_W-1:0] cnt_next [NCNT];
   logic [NCNT-1:0]  inc_en;
   logic [NCNT-1:0]  cnt_wr;
   logic [31:0]      inh_reg, inh_next;
   logic [31:0]      rdata_reg, rdata_next;
   logic             rvalid_reg, hit_reg;

   csr_op_sel_t      op;
   logic [4:0]       idx;
   logic             sel_lo, sel_hi, sel_inh, idx_ok, mapped, wr_en;
   logic [CNT_W-1:0] sel_cnt;
   logic [31:0]      old_val, new_val;

   assign op      = csr_op_sel_t'(csr_op_sel);
   assign idx     = csr_addr[4:0];
   assign sel_lo  = (csr_addr[11:5] == 7'b1011000);
   assign sel_hi  = (csr_addr[11:5] == 7'b1011100);
   assign sel_inh = (csr_addr == ADDR_INH);
   assign idx_ok  = (idx != 5'd1) && (32'(idx) < NCNT);
   assign mapped  = ((sel_lo | sel_hi) & idx_ok) | sel_inh;
   assign wr_en   = csr_en & csr_we & (op != OP_NONE) & mapped;

   always_comb begin
      sel_cnt = '0;
      for (int k = 0; k < NCNT; k++) begin
         if (idx == 5'(k)) sel_cnt = cnt_reg[k];
      end
   end

   always_comb begin
      old_val = '0;
      if (sel_inh)
         old_val = inh_reg;
      else if (idx_ok && sel_lo)
         old_val = sel_cnt[31:0];
      else if (idx_ok && sel_hi)
         old_val = 32'(sel_cnt[CNT_W-1:32]);
   end

   always_comb begin
      case (op)
         OP_ASSIGN: new_val = csr_wdata;
         OP_SET:    new_val = old_val | csr_wdata;
         OP_CLR:    new_val = old_val & ~csr_wdata;
         default:   new_val = old_val;
      endcase
   end

   for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
      if (gi == 0) begin : g_cy
         assign inc_en[gi] = ~inh_reg[0];
      end else if (gi == 1) begin : g_rsvd
         assign inc_en[gi] = 1'b0;
      end else if (gi == 2) begin : g_ir
         assign inc_en[gi] = inst_retired & ~inh_reg[2];
      end else begin : g_hpm
         assign inc_en[gi] = hpm_evt[gi-3] & ~inh_reg[gi];
      end

      assign cnt_wr[gi] = wr_en & (sel_lo | sel_hi) & (idx == 5'(gi));

      // A write replaces the addressed half and suppresses the increment for the whole counter
      assign cnt_next[gi] = cnt_wr[gi]
                          ? (sel_lo ? {cnt_reg[gi][CNT_W-1:32], new_val}
                                    : {new_val[CNT_W-33:0], cnt_reg[gi][31:0]})
                          : (inc_en[gi] ? cnt_reg[gi] + CNT_ONE : cnt_reg[gi]);
   end

   assign inh_next   = (wr_en && sel_inh) ? (new_val & INH_MASK) : inh_reg;
   assign rdata_next = (csr_en && mapped) ? old_val : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NCNT; k++) cnt_reg[k] <= '0;
         inh_reg    <= '0;
         rdata_reg  <= '0;
         rvalid_reg <= 1'b0;
         hit_reg    <= 1'b0;
      end else begin
         for (int k = 0; k < NCNT; k++) cnt_reg[k] <= cnt_next[k];
         inh_reg    <= inh_next;
         rdata_reg  <= rdata_next;
         rvalid_reg <= csr_en;
         hit_reg    <= csr_en & mapped;
      end
   end

   assign csr_rdata  = rdata_reg;
   assign csr_rvalid = rvalid_reg;
   assign csr_hit    = hit_reg;

endmodule

// File: tb/tb_ama_riscv_csr_cnt.sv
// Directed and randomized checks of ama_riscv_csr_cnt against a per-cycle behavioural model.
module tb_ama_riscv_csr_cnt;

   localparam int NUM_HPM = 4;
   localparam int CNT_W   = 64;
   localparam int HW      = (NUM_HPM > 0) ? NUM_HPM : 1;
   localparam int NCNT    = 3 + NUM_HPM;

   logic          clk = 1'b0;
   logic          rst, csr_en, csr_we, inst_retired;
   logic [1:0]    csr_op_sel;
   logic [11:0]   csr_addr;
   logic [31:0]   csr_wdata;
   logic [HW-1:0] hpm_evt;
   logic [31:0]   csr_rdata;
   logic          csr_rvalid, csr_hit;

   ama_riscv_csr_cnt #(.NUM_HPM(NUM_HPM), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .csr_en(csr_en), .csr_we(csr_we),
      .csr_op_sel(csr_op_sel), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .inst_retired(inst_retired), .hpm_evt(hpm_evt),
      .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid), .csr_hit(csr_hit)
   );

   always #5 clk = ~clk;

   // Reference state: counters as plain integers, index = address offset (slot 1 never used)
   logic [63:0]   m_cnt [0:NCNT-1];
   logic [31:0]   m_inh;
   logic [63:0]   cmask;
   logic          ir_v;
   logic [HW-1:0] ev_v;
   logic [31:0]   last_rd;
   int            n_checks = 0;
   int            n_err    = 0;
   int            n_step   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s step=%0d: observed=%h expected=%h", tag, n_step, got, exp);
      end
   endtask

   function automatic void decode(input logic [11:0] a, output int kind, output int k);
      kind = 0;
      k    = 0;
      if (a == 12'h320) kind = 3;
      for (int j = 0; j < NCNT; j++) begin
         if (j != 1 && a == 12'hB00 + 12'(j)) begin kind = 1; k = j; end
         if (j != 1 && a == 12'hB80 + 12'(j)) begin kind = 2; k = j; end
      end
   endfunction

   task automatic step(input logic r, input logic en, input logic we, input logic [1:0] op,
                       input logic [11:0] a, input logic [31:0] wd);
      int          kind, k;
      logic [31:0] old, nv, legal, e_rd;
      logic        wr, inc, e_v, e_h;
      rst = r; csr_en = en; csr_we = we; csr_op_sel = op; csr_addr = a; csr_wdata = wd;
      inst_retired = ir_v; hpm_evt = ev_v;
      decode(a, kind, k);
      case (kind)
         1:       old = m_cnt[k][31:0];
         2:       old = m_cnt[k][63:32];
         3:       old = m_inh;
         default: old = 32'h0;
      endcase
      case (op)
         2'd1:    nv = wd;
         2'd2:    nv = old | wd;
         2'd3:    nv = old & ~wd;
         default: nv = old;
      endcase
      legal = 32'h0;
      for (int j = 0; j < 32; j++) legal[j] = (j == 0) || (j == 2) || (j >= 3 && j < NCNT);
      e_v = !r && en;
      e_h = !r && en && (kind != 0);
      e_rd = e_h ? old : 32'h0;
      wr = !r && en && we && (op != 2'd0) && (kind != 0);
      if (r) begin
         for (int j = 0; j < NCNT; j++) m_cnt[j] = 64'h0;
         m_inh = 32'h0;
      end else begin
         for (int j = 0; j < NCNT; j++) begin
            inc = 1'b0;
            if (j == 0) inc = !m_inh[0];
            else if (j == 2) inc = ir_v && !m_inh[2];
            else if (j >= 3) inc = ev_v[j-3] && !m_inh[j];
            if (wr && (kind == 1 || kind == 2) && k == j) inc = 1'b0;
            if (inc) m_cnt[j] = (m_cnt[j] + 64'd1) & cmask;
         end
         if (wr && kind == 1) m_cnt[k][31:0] = nv;
         if (wr && kind == 2) m_cnt[k] = {nv, m_cnt[k][31:0]} & cmask;
         if (wr && kind == 3) m_inh = nv & legal;
      end
      @(posedge clk);
      #1;
      n_step++;
      check("rvalid", {31'h0, csr_rvalid}, {31'h0, e_v});
      check("hit",    {31'h0, csr_hit},    {31'h0, e_h});
      check("rdata",  csr_rdata, e_rd);
      last_rd = csr_rdata;
   endtask

   task automatic idle();  step(1'b0, 1'b0, 1'b0, 2'd0, 12'h000, 32'h0); endtask
   task automatic rd(input logic [11:0] a);  step(1'b0, 1'b1, 1'b0, 2'd0, a, 32'h0); endtask
   task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
      step(1'b0, 1'b1, 1'b1, op, a, d);
   endtask

   logic [11:0] addrs [16];

   initial begin
      cmask = (CNT_W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CNT_W) - 64'd1);
      ir_v = 1'b0; ev_v = '0;
      for (int j = 0; j < NCNT; j++) m_cnt[j] = 64'h0;
      m_inh = 32'h0;

      // Reset, then count 10 idle cycles
      step(1'b1, 1'b0, 1'b0, 2'd0, 12'h000, 32'h0);
      for (int i = 0; i < 10; i++) idle();
      rd(12'hB00);  check("mcycle_after_10", last_rd, 32'd10);
      rd(12'hB80);  check("mcycleh_zero", last_rd, 32'd0);

      // Carry from low half into high half
      wr(2'd1, 12'hB00, 32'hFFFF_FFFF);
      wr(2'd1, 12'hB80, 32'h0);
      idle();
      rd(12'hB80);  check("carry_hi", last_rd, 32'd1);
      rd(12'hB00);  check("carry_lo_small", last_rd, 32'd1);

      // Full 64-bit wrap; inhibit CY while loading all-ones, release for exactly one increment
      wr(2'd1, 12'h320, 32'h1);
      wr(2'd1, 12'hB80, 32'hFFFF_FFFF);
      wr(2'd1, 12'hB00, 32'hFFFF_FFFF);
      wr(2'd3, 12'h320, 32'h1);
      wr(2'd2, 12'h320, 32'h1);
      rd(12'hB80);  check("wrap_hi", last_rd, 32'd0);
      rd(12'hB00);  check("wrap_lo", last_rd, 32'd0);

      // minstret inhibit, bit1 hardwired zero
      wr(2'd1, 12'h320, 32'h6);
      rd(12'h320);  check("inh_bit1_zero", last_rd, 32'h4);
      ir_v = 1'b1;
      for (int i = 0; i < 5; i++) idle();
      ir_v = 1'b0;
      rd(12'hB02);  check("minstret_inhibited", last_rd, 32'd0);
      wr(2'd3, 12'h320, 32'h4);
      ir_v = 1'b1;
      for (int i = 0; i < 3; i++) idle();
      ir_v = 1'b0;
      rd(12'hB02);  check("minstret_3", last_rd, 32'd3);

      // Write beats a simultaneous event; SET returns the old value
      ev_v = 4'b0010;
      wr(2'd1, 12'hB04, 32'h100);
      ev_v = '0;
      rd(12'hB04);  check("hpm4_write_wins", last_rd, 32'h100);
      wr(2'd2, 12'hB04, 32'h3);
      check("hpm4_set_old", last_rd, 32'h100);
      ev_v = 4'b0010;
      idle(); idle();
      ev_v = '0;
      rd(12'hB04);  check("hpm4_set_plus_evt", last_rd, 32'h105);

      // Unmapped accesses, then reset during a write
      wr(2'd1, 12'hB01, 32'hDEAD_BEEF);
      check("unmapped_b01_hit", {31'h0, csr_hit}, 32'h0);
      wr(2'd1, 12'h7C0, 32'hDEAD_BEEF);
      check("unmapped_7c0_rd", last_rd, 32'h0);
      rd(12'hB02);  check("minstret_unchanged", last_rd, 32'd3);
      step(1'b1, 1'b1, 1'b1, 2'd1, 12'hB02, 32'h55);
      check("rst_rvalid", {31'h0, csr_rvalid}, 32'h0);
      rd(12'hB02);  check("rst_minstret", last_rd, 32'd0);

      // Randomized traffic over mapped and unmapped addresses
      addrs[0]  = 12'hB00; addrs[1]  = 12'hB80; addrs[2]  = 12'hB02; addrs[3]  = 12'hB82;
      addrs[4]  = 12'hB03; addrs[5]  = 12'hB04; addrs[6]  = 12'hB05; addrs[7]  = 12'hB06;
      addrs[8]  = 12'hB83; addrs[9]  = 12'hB86; addrs[10] = 12'h320; addrs[11] = 12'hB01;
      addrs[12] = 12'hB81; addrs[13] = 12'hB07; addrs[14] = 12'hB87; addrs[15] = 12'h7C0;
      for (int i = 0; i < 400; i++) begin
         logic [31:0] d;
         ir_v = 1'($urandom_range(0, 1));
         ev_v = HW'($urandom);
         d = $urandom;
         if ($urandom_range(0, 3) == 0) d = {$urandom_range(0, 1) == 0 ? 32'h0 : 32'hFFFF_FFFF} ^ 32'(i & 1);
         step(($urandom_range(0, 79) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), addrs[$urandom_range(0, 15)], d);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/ama_riscv_csr_cnt.md
Name: ama_riscv_csr_cnt

Overview:
Parametrised machine counter bank. It generalises the fixed mcycle/minstret pair to mcycle, minstret, NUM_HPM event counters (mhpmcounter3..) and an mcountinhibit register. Each counter is CNT_W wide and accessed as 32-bit low/high halves with assign/set/clear CSR semantics. It sits beside the core CSR file in the EXE stage and is accessed via a 1-cycle registered read port.

Parameters:
NUM_HPM, 4, number of event counters mhpmcounter3..(3+NUM_HPM-1); legal range 0..29
CNT_W, 64, counter width; legal range 33..64; bits above CNT_W read as zero

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
csr_en  input  1  CSR access valid this cycle
csr_we  input  1  write enable; qualified by csr_en
csr_op_sel  input  2  csr_op_sel_t: NONE/ASSIGN/SET_BITS/CLR_BITS
csr_addr  input  12  CSR address
csr_wdata  input  32  write operand
inst_retired  input  1  one instruction retired this cycle
hpm_evt  input  max(NUM_HPM,1)  per-counter event pulse; bit i drives mhpmcounter(3+i)
csr_rdata  output  32  registered read data
csr_rvalid  output  1  registered; high for exactly one cycle after each csr_en
csr_hit  output  1  registered; address mapped, valid with csr_rvalid

Behaviour:
- Address map:
  - mcycle 0xB00, mcycleh 0xB80
  - minstret 0xB02, minstreth 0xB82
  - mhpmcounter(3+i) at 0xB03+i, high half at 0xB83+i
  - mcountinhibit 0x320
  - Any other address, or 0xB01/0xB81, is unmapped.
- mcountinhibit layout:
  - bit0 CY, bit2 IR, bit(3+i) HPM i.
  - bit1 and bits above 3+NUM_HPM-1 are hardwired 0: writes ignored, read 0.
- Increment, per cycle, when the inhibit bit is 0:
  - mcycle increments every cycle.
  - minstret increments when inst_retired=1.
  - mhpmcounter(3+i) increments when hpm_evt[i]=1.
  - Increment is +1 modulo 2^CNT_W: all-ones wraps to 0, with no flag.
- Write:
  - Occurs when csr_en & csr_we & op_sel!=NONE & address mapped.
  - old = current 32-bit view of the addressed half.
  - ASSIGN gives new=wdata; SET gives new=old|wdata; CLR gives new=old&~wdata.
  - Low half write replaces bits [31:0]; high half write replaces bits [CNT_W-1:32], with wdata bits above CNT_W-33 discarded.
- Write vs increment in the same cycle:
  - The write wins for the whole counter; no increment occurs that cycle.
  - Next cycle the counter holds exactly the written composite value; for high-half writes the low half is kept unincremented.
- mcountinhibit write:
  - Takes effect from the next cycle.
  - The inhibit value before the write governs increments in the write cycle.
- Read:
  - On csr_en, next cycle csr_rvalid=1, csr_hit=mapped, csr_rdata = pre-write, pre-increment value of the addressed half (the old value sampled in the access cycle).
  - Unmapped address: csr_rdata=0, csr_hit=0, no state change.
  - csr_en=0 next cycle gives csr_rvalid=0, csr_hit=0, csr_rdata=0.
- Back-to-back accesses are allowed every cycle; there is no backpressure (always ready).
- csr_we=1 with csr_en=0 is ignored.
- Reset:
  - All counters, mcountinhibit, csr_rdata, csr_rvalid and csr_hit go to 0.
  - rst overrides any write or increment in the same cycle, including mid-sequence.
  - The first increment of mcycle occurs in the first cycle after rst deasserts.
- NUM_HPM=0: no event counters; hpm_evt is a 1-bit input and is unused; 0xB03+ are unmapped.

Test Plan:
- Reset released, idle 10 cycles, then read 0xB00 → rdata=10 (counting from the first post-reset cycle as 1 up to the read-sample cycle, inclusive), rvalid=1, hit=1; read 0xB80 → 0.
- ASSIGN 0xFFFFFFFF to 0xB00 and ASSIGN 0x0 to 0xB80, idle 1 cycle, read 0xB80 → 0x1 (carry into high half); read 0xB00 → small count, not 0xFFFFFFFF.
- CNT_W=64, set mcycle to all-ones via two ASSIGNs, let it run 1 increment → both halves read 0 after wrap.
- Write mcountinhibit=0x4, pulse inst_retired 5 cycles, read 0xB02 → 0; clear bit 2 via CLR_BITS 0x4, pulse 3 → read 3; read 0x320 with bit1 written as 1 → bit1 reads 0.
- hpm_evt[1]=1 held in the same cycle as ASSIGN 0x100 to 0xB04 → next read 0xB04=0x100 + subsequent event count only; SET_BITS 0x3 on 0xB04 holding 0x100 → rdata shows 0x100 (old), later read 0x103 plus events.
- Access to 0xB01 and 0x7C0 → hit=0, rdata=0, no state change; assert rst during a write cycle to 0xB02 → minstret=0 afterwards, rvalid=0.
